// File: rtl/fetch_byte_queue.sv
// Byte-granular circular queue feeding the x86-64 decoder window.
// Accepts 8-byte fetch words, retires decoder-consumed bytes.
module fetch_byte_queue #(
    parameter int DEPTH_BYTES  = 32,
    parameter int FILL_BYTES   = 8,
    parameter int WINDOW_BYTES = 15
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          flush,
    input  logic                          fill_valid,
    output logic                          fill_ready,
    input  logic [8*FILL_BYTES-1:0]       fill_data,
    output logic [0:8*WINDOW_BYTES-1]     window_data,
    output logic [3:0]                    window_bytes,
    input  logic [3:0]                    consume_bytes,
    output logic                          underflow_err
);

    localparam int PTR_W = $clog2(DEPTH_BYTES);
    localparam int CNT_W = $clog2(DEPTH_BYTES + 1);

    logic [7:0]       storage [DEPTH_BYTES];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_next;
    logic             fill_fire;
    logic             cons_ok;

    // Handshake and consume legality, all from pre-update count
    always_comb begin
        fill_ready = !reset && !flush
                     && (count <= CNT_W'(DEPTH_BYTES - FILL_BYTES));
        fill_fire  = fill_valid && fill_ready;
        cons_ok    = (CNT_W'(consume_bytes) <= count);
        count_next = count
                     + (fill_fire ? CNT_W'(FILL_BYTES) : '0)
                     - (cons_ok ? CNT_W'(consume_bytes) : '0);
    end

    // Byte storage; fill word lands little-endian at tail
    always_ff @(posedge clk) begin
        if (fill_fire) begin
            for (int i = 0; i < FILL_BYTES; i++) begin
                storage[tail + PTR_W'(i)] <= fill_data[8*i +: 8];
            end
        end
    end

    // Pointers, occupancy and sticky underflow flag
    always_ff @(posedge clk) begin
        if (reset) begin
            head          <= '0;
            tail          <= '0;
            count         <= '0;
            underflow_err <= 1'b0;
        end else if (flush) begin
            head          <= '0;
            tail          <= '0;
            count         <= '0;
            underflow_err <= 1'b0;
        end else begin
            if (fill_fire) begin
                tail <= tail + PTR_W'(FILL_BYTES);
            end
            if (cons_ok) begin
                head <= head + PTR_W'(consume_bytes);
            end else begin
                underflow_err <= 1'b1;
            end
            count <= count_next;
        end
    end

    // Decode window: oldest byte first, unfilled slots forced to zero
    always_comb begin
        window_data = '0;
        for (int k = 0; k < WINDOW_BYTES; k++) begin
            if (!reset && (CNT_W'(k) < count)) begin
                window_data[8*k +: 8] = storage[head + PTR_W'(k)];
            end
        end
    end

    // Valid byte count presented to the decoder, saturated at window size
    always_comb begin
        window_bytes = '0;
        if (!reset) begin
            if (count >= CNT_W'(WINDOW_BYTES)) begin
                window_bytes = 4'(WINDOW_BYTES);
            end else begin
                window_bytes = count[3:0];
            end
        end
    end

endmodule

// File: tb/tb_fetch_byte_queue.sv
// Bench for fetch_byte_queue: directed cases plus random traffic
// checked against a byte-queue reference model.
module tb_fetch_byte_queue;

    logic          clk = 1'b0;
    logic          reset;
    logic          flush;
    logic          fill_valid;
    logic          fill_ready;
    logic [63:0]   fill_data;
    logic [0:119]  window_data;
    logic [3:0]    window_bytes;
    logic [3:0]    consume_bytes;
    logic          underflow_err;

    int errors = 0;
    int checks = 0;

    logic [7:0] q [$];
    logic       err_m = 1'b0;

    fetch_byte_queue dut (
        .clk           (clk),
        .reset         (reset),
        .flush         (flush),
        .fill_valid    (fill_valid),
        .fill_ready    (fill_ready),
        .fill_data     (fill_data),
        .window_data   (window_data),
        .window_bytes  (window_bytes),
        .consume_bytes (consume_bytes),
        .underflow_err (underflow_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got,
                         input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [0:119] model_window();
        logic [0:119] w;
        w = '0;
        for (int k = 0; k < 15; k++) begin
            if (k < q.size()) w[8*k +: 8] = q[k];
        end
        return w;
    endfunction

    task automatic step(input logic r, input logic fl, input logic fv,
                        input logic [63:0] d, input logic [3:0] c);
        logic er;
        int   n;
        @(negedge clk);
        reset = r;
        flush = fl;
        fill_valid = fv;
        fill_data = d;
        consume_bytes = c;
        #1;
        er = !r && !fl && (q.size() <= 24);
        check("fill_ready", 128'(fill_ready), 128'(er));
        @(posedge clk);
        if (r || fl) begin
            q.delete();
            err_m = 1'b0;
        end else begin
            if (int'(c) <= q.size()) begin
                for (int i = 0; i < int'(c); i++) void'(q.pop_front());
            end else begin
                err_m = 1'b1;
            end
            if (fv && er) begin
                for (int i = 0; i < 8; i++) q.push_back(d[8*i +: 8]);
            end
        end
        #1;
        n = (q.size() >= 15) ? 15 : q.size();
        check("window_bytes", 128'(window_bytes), 128'(n));
        check("window_data", 128'(window_data), 128'(model_window()));
        check("underflow_err", 128'(underflow_err), 128'(err_m));
    endtask

    function automatic logic [63:0] word(input int base);
        logic [63:0] w;
        for (int i = 0; i < 8; i++) w[8*i +: 8] = 8'(base + i);
        return w;
    endfunction

    initial begin
        logic [63:0] rd;
        logic [3:0]  rc;
        logic [0:63] lo;
        reset = 1'b1;
        flush = 1'b0;
        fill_valid = 1'b0;
        fill_data = '0;
        consume_bytes = '0;

        // reset state
        step(1, 0, 0, '0, 0);
        check("rst_window", 128'(window_data), 128'(0));
        check("rst_bytes", 128'(window_bytes), 128'(0));

        // single fill
        step(0, 0, 1, 64'h0706050403020100, 0);
        lo = window_data[0:63];
        check("t1_lo", 128'(lo), 128'(64'h0001020304050607));
        check("t1_bytes", 128'(window_bytes), 128'(8));

        // fill to full, then consume 15
        step(0, 0, 1, word(8), 0);
        step(0, 0, 1, word(16), 0);
        step(0, 0, 1, word(24), 0);
        check("t2_full", 128'(fill_ready), 128'(0));
        step(0, 0, 0, '0, 15);
        check("t2_ready", 128'(fill_ready), 128'(1));
        check("t2_b0", 128'(window_data[0:7]), 128'(8'd15));

        // head to 28 then two fills: wrapped window
        step(0, 0, 0, '0, 13);
        step(0, 0, 1, word(32), 0);
        step(0, 0, 1, word(40), 0);
        check("t3_b0", 128'(window_data[0:7]), 128'(8'd28));
        check("t3_b14", 128'(window_data[112:119]), 128'(8'd42));

        // simultaneous fill and consume
        step(1, 0, 0, '0, 0);
        step(0, 0, 1, word(0), 0);
        step(0, 0, 1, word(8), 3);
        check("t4_bytes", 128'(window_bytes), 128'(13));
        check("t4_b0", 128'(window_data[0:7]), 128'(8'd3));

        // underflow then flush
        step(1, 0, 0, '0, 0);
        step(0, 0, 1, word(0), 0);
        step(0, 0, 0, '0, 3);
        step(0, 0, 0, '0, 9);
        check("t5_err", 128'(underflow_err), 128'(1));
        check("t5_bytes", 128'(window_bytes), 128'(5));
        step(0, 0, 0, '0, 0);
        check("t5_sticky", 128'(underflow_err), 128'(1));
        step(0, 1, 0, '0, 0);
        check("t5_clr", 128'(underflow_err), 128'(0));

        // empty consume of 0 raises nothing
        step(0, 0, 0, '0, 0);
        check("t5_noop", 128'(underflow_err), 128'(0));

        // flush with fill and consume, then reset mid-fill
        step(0, 0, 1, word(0), 0);
        step(0, 1, 1, word(8), 2);
        check("t6_empty", 128'(window_bytes), 128'(0));
        step(0, 0, 1, word(16), 0);
        step(1, 0, 1, word(24), 0);
        check("t6_rst", 128'(window_data), 128'(0));
        step(0, 0, 0, '0, 0);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            rd = {$urandom, $urandom};
            if ($urandom_range(0, 7) == 0) rc = 4'($urandom_range(0, 15));
            else rc = 4'($urandom_range(0, 8));
            step(($urandom_range(0, 199) == 0),
                 ($urandom_range(0, 49) == 0),
                 ($urandom_range(0, 3) != 0),
                 rd, rc);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
